// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor
// Bridges the cache's whole-line physical-memory port to a narrow burst bus.
// A line fill is collected from `beats` consecutive read beats. A write-back
// is split into `beats` write beats. Beat 0 carries bits [s_burst-1:0].
// Completion is reported to the cache with a one-cycle line_resp pulse.
//
// Ports
//   clk, rst       clock, synchronous active-high reset
//   line_address   line address from the cache
//   line_read      line fill request (held until line_resp)
//   line_write     line write-back request (held until line_resp, wins over read)
//   line_wdata     line to write back
//   line_rdata     assembled fill line, valid from line_resp until the next fill
//   line_resp      one-cycle completion pulse
//   burst_address  line-aligned memory address
//   burst_read     memory read request
//   burst_write    memory write request
//   burst_wdata    write beat currently presented
//   burst_rdata    read beat returned by memory
//   burst_resp     memory beat valid / beat accepted strobe
module cacheline_adaptor #(
  parameter int s_line   = 256,
  parameter int s_burst  = 64,
  parameter int s_addr   = 32,
  parameter int s_offset = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [s_addr-1:0]   line_address,
  input  logic                line_read,
  input  logic                line_write,
  input  logic [s_line-1:0]   line_wdata,
  output logic [s_line-1:0]   line_rdata,
  output logic                line_resp,
  output logic [s_addr-1:0]   burst_address,
  output logic                burst_read,
  output logic                burst_write,
  output logic [s_burst-1:0]  burst_wdata,
  input  logic [s_burst-1:0]  burst_rdata,
  input  logic                burst_resp
);

  localparam int beats = s_line / s_burst;
  localparam int cnt_w = (beats > 1) ? $clog2(beats) : 1;
  // Clears the line-offset bits so memory always sees a line-aligned address.
  localparam logic [s_addr-1:0] addr_mask = ~(s_addr'((1 << s_offset) - 1));

  typedef enum logic [1:0] {
    IDLE,
    RD_BURST,
    WR_BURST,
    DONE
  } state_t;

  state_t             state;
  logic [cnt_w-1:0]   count;
  logic [s_line-1:0]  wbuf;
  logic               last_beat;

  assign last_beat = (count == cnt_w'(beats - 1));

  // Control FSM and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      count         <= '0;
      line_rdata    <= '0;
      line_resp     <= 1'b0;
      burst_read    <= 1'b0;
      burst_write   <= 1'b0;
      burst_address <= '0;
      burst_wdata   <= '0;
    end else begin
      line_resp <= 1'b0;
      case (state)
        IDLE: begin
          if (line_write) begin
            state         <= WR_BURST;
            burst_write   <= 1'b1;
            burst_address <= line_address & addr_mask;
            burst_wdata   <= line_wdata[s_burst-1:0];
            count         <= '0;
          end else if (line_read) begin
            state         <= RD_BURST;
            burst_read    <= 1'b1;
            burst_address <= line_address & addr_mask;
            count         <= '0;
          end
        end
        RD_BURST: begin
          if (burst_resp) begin
            for (int k = 0; k < beats; k++) begin
              if (count == cnt_w'(k)) begin
                line_rdata[k*s_burst +: s_burst] <= burst_rdata;
              end
            end
            count <= count + 1'b1;
            if (last_beat) begin
              state      <= DONE;
              burst_read <= 1'b0;
              line_resp  <= 1'b1;
            end
          end
        end
        WR_BURST: begin
          if (burst_resp) begin
            // wbuf already holds the not-yet-presented beats in its low bits.
            burst_wdata <= wbuf[s_burst-1:0];
            count       <= count + 1'b1;
            if (last_beat) begin
              state       <= DONE;
              burst_write <= 1'b0;
              line_resp   <= 1'b1;
            end
          end
        end
        DONE: begin
          // Requests still high here are deliberately ignored.
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write shift buffer: pure data, no reset needed
  always_ff @(posedge clk) begin
    if (state == IDLE && line_write) begin
      wbuf <= line_wdata >> s_burst;
    end else if (state == WR_BURST && burst_resp) begin
      wbuf <= wbuf >> s_burst;
    end
  end

endmodule
